uart_tx_core: RTL and testbench

- Serial side of the UART byte interface driven by the AHB-lite UART peripheral; that peripheral emits a one-cycle tx_en strobe with a byte and polls a status bit.
- Buffers bytes in a small FIFO and serialises them on TXD as 8N1 frames: idle high, start bit 0, 8 data bits LSB first, stop bit 1.
- Returns "can accept" status on state; the peripheral reads it at offset 0x4.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_fifo.sv | 66 ++++++
 rtl/uart_tx_core.sv | 124 ++++++++++++
 tb/tb_uart_tx_core.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS        = 8;
    localparam int UART_FRAME_BITS       = 10;
    localparam int UART_BAUD_DIV_DEFAULT = 434;

    // Serial line level for a given FSM state and shift register contents.
    function automatic logic line_level(input uart_state_e st, input logic [7:0] shift);
        logic lvl;
        case (st)
            IDLE:    lvl = 1'b1;
            START:   lvl = 1'b0;
            DATA:    lvl = shift[0];
            STOP:    lvl = 1'b1;
            default: lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter; head entry is kept in a register so pop data is always ready.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic [7:0] pop_data_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [7:0]       head_q, head_d;
    logic             push_ok_s, pop_ok_s;

    assign full_o     = (cnt_q == DEPTH_C);
    assign empty_o    = (cnt_q == {(PTR_W + 1){1'b0}});
    assign pop_data_o = head_q;

    // Pointer, count and head-entry next state; fullness is judged before any same-edge pop.
    always_comb begin
        push_ok_s = push_i && !full_o;
        pop_ok_s  = pop_i && !empty_o;
        wr_d      = push_ok_s ? wr_q + PTR_W'(1) : wr_q;
        rd_d      = pop_ok_s ? rd_q + PTR_W'(1) : rd_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
        if (push_ok_s && (wr_q == rd_d)) begin
            head_d = push_data_i;
        end else begin
            head_d = mem_q[rd_d];
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_q   <= {PTR_W{1'b0}};
            rd_q   <= {PTR_W{1'b0}};
            cnt_q  <= {(PTR_W + 1){1'b0}};
            head_q <= 8'h00;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_q] <= push_data_i;
            end
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter: byte FIFO, baud counter, framing FSM and registered serial output.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = UART_BAUD_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       tx_en,
    input  logic [7:0] UART_TX,
    output logic       state,
    output logic       TXD,
    output logic       tx_busy,
    output logic       tx_overflow
);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_state_e fsm_q, fsm_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        ovf_q, ovf_d;
    logic        bit_end_s, pop_s, full_s, empty_s;
    logic [7:0]  pop_data_s;

    uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i      (HCLK),
        .rst_ni     (HRESETn),
        .push_i     (tx_en),
        .push_data_i(UART_TX),
        .pop_i      (pop_s),
        .pop_data_o (pop_data_s),
        .full_o     (full_s),
        .empty_o    (empty_s)
    );

    assign bit_end_s   = (baud_q == BAUD_LAST);
    assign state       = !full_s;
    assign tx_busy     = (fsm_q != IDLE) || !empty_s;
    assign TXD         = txd_q;
    assign tx_overflow = ovf_q;

    // Framing FSM; TXD is computed from the next state so the line changes on the transition edge.
    always_comb begin
        fsm_d     = fsm_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop_s     = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = pop_data_s;
                    fsm_d   = START;
                end else begin
                    fsm_d = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    fsm_d     = DATA;
                    bit_idx_d = 3'd0;
                end else begin
                    fsm_d = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q < LAST_BIT) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else begin
                        fsm_d = STOP;
                    end
                end else begin
                    fsm_d = DATA;
                end
            end
            STOP: begin
                if (bit_end_s && !empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = pop_data_s;
                    fsm_d   = START;
                end else if (bit_end_s) begin
                    fsm_d = IDLE;
                end else begin
                    fsm_d = STOP;
                end
            end
            default: fsm_d = IDLE;
        endcase

        if ((fsm_d != fsm_q) || bit_end_s || (fsm_q == IDLE)) begin
            baud_d = 16'd0;
        end else begin
            baud_d = baud_q + 16'd1;
        end
        txd_d = line_level(fsm_d, shift_d);
        ovf_d = tx_en && full_s;
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            fsm_q     <= IDLE;
            baud_q    <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            txd_q     <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core against a frame-timeline reference model.
module tb_uart_tx_core;
    localparam int BAUD  = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * BAUD;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       tx_en = 1'b0;
    logic [7:0] UART_TX = 8'h00;
    logic       state, TXD, tx_busy, tx_overflow;

    int checks = 0;
    int errors = 0;

    uart_tx_core #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .tx_en      (tx_en),
        .UART_TX    (UART_TX),
        .state      (state),
        .TXD        (TXD),
        .tx_busy    (tx_busy),
        .tx_overflow(tx_overflow)
    );

    initial forever #5 HCLK = ~HCLK;

    // Reference model: queue of accepted bytes plus position within the frame being sent.
    logic [7:0] mq[$];
    logic       m_active = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_cur = 8'h00;
    logic       m_full = 1'b0;
    logic       m_ovf = 1'b0, m_txd = 1'b1, m_busy = 1'b0, m_state = 1'b1;

    function automatic logic fbit(input logic [7:0] b, input int p);
        int s;
        s = p / BAUD;
        if (s == 0) return 1'b0;
        else if (s == 9) return 1'b1;
        else return b[s-1];
    endfunction

    initial forever begin
        @(posedge HCLK or negedge HRESETn);
        if (!HRESETn) begin
            mq.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovf    = 1'b0;
        end else begin
            m_full = (mq.size() == DEPTH);
            if (m_active) begin
                m_pos++;
                if (m_pos == FRAME) m_active = 1'b0;
            end
            if (!m_active && mq.size() != 0) begin
                m_cur    = mq.pop_front();
                m_active = 1'b1;
                m_pos    = 0;
            end
            m_ovf = tx_en && m_full;
            if (tx_en && !m_full) mq.push_back(UART_TX);
        end
        m_txd   = m_active ? fbit(m_cur, m_pos) : 1'b1;
        m_busy  = m_active || (mq.size() != 0);
        m_state = (mq.size() != DEPTH);
    end

    task automatic test_reset();
        HRESETn = 1'b0;
        tx_en   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            checks++;
            if ({TXD, tx_busy, state, tx_overflow} !== 4'b1010) begin
                errors++;
                $display("FAIL reset cyc=%0d txd/busy/state/ovf got=%b required=1010", i,
                         {TXD, tx_busy, state, tx_overflow});
            end
            if (i == 2) HRESETn = 1'b1;
        end
    endtask

    task automatic test_single();
        logic       cap [FRAME];
        logic [9:0] frm;
        frm = {1'b1, 8'hA5, 1'b0};
        @(negedge HCLK);
        tx_en = 1'b1; UART_TX = 8'hA5;
        for (int i = 0; i <= 42; i++) begin
            @(negedge HCLK);
            checks++;
            if ({TXD, tx_busy, state, tx_overflow} !== {m_txd, m_busy, m_state, m_ovf}) begin
                errors++;
                $display("FAIL single cyc=%0d txd/busy/state/ovf got=%b required=%b", i,
                         {TXD, tx_busy, state, tx_overflow}, {m_txd, m_busy, m_state, m_ovf});
            end
            if (i >= 1 && i <= FRAME) cap[i-1] = TXD;
            if (i == 41) begin
                checks++;
                if (tx_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL single_busy_end got=%b required=0", tx_busy);
                end
            end
            tx_en = 1'b0; UART_TX = 8'($urandom);
        end
        for (int j = 0; j < FRAME; j++) begin
            checks++;
            if (cap[j] !== frm[j/BAUD]) begin
                errors++;
                $display("FAIL single_frame cyc=%0d got=%b required=%b", j, cap[j], frm[j/BAUD]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int idle_gap = 0;
        for (int i = 0; i < 3 * FRAME + 10; i++) begin
            @(negedge HCLK);
            checks++;
            if ({TXD, tx_busy, state, tx_overflow} !== {m_txd, m_busy, m_state, m_ovf}) begin
                errors++;
                $display("FAIL b2b cyc=%0d txd/busy/state/ovf got=%b required=%b", i,
                         {TXD, tx_busy, state, tx_overflow}, {m_txd, m_busy, m_state, m_ovf});
            end
            if (i >= 2 && i < 2 + 3 * FRAME && !tx_busy) idle_gap++;
            tx_en   = (i < 3);
            UART_TX = 8'(i + 1);
        end
        checks++;
        if (idle_gap != 0) begin
            errors++;
            $display("FAIL b2b_contiguous idle cycles got=%0d required=0", idle_gap);
        end
    endtask

    task automatic test_overflow();
        int ovf_seen = 0;
        for (int i = 0; i < 6 * FRAME; i++) begin
            @(negedge HCLK);
            checks++;
            if ({TXD, tx_busy, state, tx_overflow} !== {m_txd, m_busy, m_state, m_ovf}) begin
                errors++;
                $display("FAIL ovf cyc=%0d txd/busy/state/ovf got=%b required=%b", i,
                         {TXD, tx_busy, state, tx_overflow}, {m_txd, m_busy, m_state, m_ovf});
            end
            if (tx_overflow) ovf_seen++;
            if (i < 5) begin
                checks++;
                if (state !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_state_fill cyc=%0d got=%b required=1", i, state);
                end
            end
            tx_en   = (i < 5) || (i >= 8 && i < 14);
            UART_TX = (i < 5) ? 8'(8'h10 + i) : 8'($urandom);
        end
        checks++;
        if (ovf_seen != 6) begin
            errors++;
            $display("FAIL ovf_pulses got=%0d required=6", ovf_seen);
        end
    endtask

    task automatic test_full_stop_pop();
        int  n = 0;
        logic hit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge HCLK);
            tx_en = 1'b1; UART_TX = 8'($urandom);
        end
        while (!hit && n < 100) begin
            @(negedge HCLK);
            tx_en = 1'b0;
            n++;
            checks++;
            if ({TXD, tx_busy, state, tx_overflow} !== {m_txd, m_busy, m_state, m_ovf}) begin
                errors++;
                $display("FAIL fullpop cyc=%0d txd/busy/state/ovf got=%b required=%b", n,
                         {TXD, tx_busy, state, tx_overflow}, {m_txd, m_busy, m_state, m_ovf});
            end
            hit = m_active && (m_pos == FRAME - 1);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL fullpop_timeout got=no_stop_end required=stop_end within 100 cycles");
        end
        tx_en = 1'b1; UART_TX = 8'hEE;
        @(negedge HCLK);
        tx_en = 1'b0;
        checks++;
        if ({tx_overflow, state} !== 2'b11) begin
            errors++;
            $display("FAIL fullpop_drop ovf/state got=%b required=11", {tx_overflow, state});
        end
        @(negedge HCLK);
        checks++;
        if (tx_overflow !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_pulse_width got=%b required=0", tx_overflow);
        end
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge HCLK);
            checks++;
            if ({TXD, tx_busy, state, tx_overflow} !== {m_txd, m_busy, m_state, m_ovf}) begin
                errors++;
                $display("FAIL fullpop_drain cyc=%0d got=%b required=%b", i,
                         {TXD, tx_busy, state, tx_overflow}, {m_txd, m_busy, m_state, m_ovf});
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            tx_en = 1'b1; UART_TX = (i == 0) ? 8'hFF : 8'($urandom);
        end
        @(negedge HCLK);
        tx_en = 1'b0;
        while (!(m_active && m_pos == 3 * BAUD + 1) && n < 100) begin
            @(negedge HCLK);
            n++;
        end
        checks++;
        if (!(m_active && m_pos == 3 * BAUD + 1)) begin
            errors++;
            $display("FAIL rstmid_timeout got=not_in_data required=in_data within 100 cycles");
        end
        HRESETn = 1'b0;
        #1;
        checks++;
        if (TXD !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_txd got=%b required=1", TXD);
        end
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge HCLK);
            checks++;
            if ({TXD, tx_busy, state, tx_overflow} !== 4'b1010) begin
                errors++;
                $display("FAIL rstmid_after cyc=%0d txd/busy/state/ovf got=%b required=1010", i,
                         {TXD, tx_busy, state, tx_overflow});
            end
        end
    endtask

    task automatic test_idle_zero();
        tx_en = 1'b0; UART_TX = 8'h00;
        for (int i = 0; i < 100; i++) begin
            @(negedge HCLK);
            checks++;
            if ({TXD, tx_busy} !== 2'b10) begin
                errors++;
                $display("FAIL idle_zero cyc=%0d txd/busy got=%b required=10", i, {TXD, tx_busy});
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3300; i++) begin
            @(negedge HCLK);
            checks++;
            if ({TXD, tx_busy, state, tx_overflow} !== {m_txd, m_busy, m_state, m_ovf}) begin
                errors++;
                $display("FAIL random cyc=%0d txd/busy/state/ovf got=%b required=%b", i,
                         {TXD, tx_busy, state, tx_overflow}, {m_txd, m_busy, m_state, m_ovf});
            end
            tx_en   = (i < 3000) && ($urandom_range(0, 24) == 0);
            UART_TX = 8'($urandom);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_stop_pop();
        test_reset_mid();
        test_idle_zero();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
